// File: rtl/clk_sw_ctrl.sv
// ---------------------------------------------------------------------------
// clk_sw_ctrl
// Sequencing controller for the glitch-free clock mux. Runs on the always-on
// clock clka, accepts clock-source switch requests over a valid/ready
// handshake, drives the registered mux select, waits out the mux handover
// (settle), pulses done, then holds off further requests for a dwell period.
//
// Parameters
//   SETTLE_CYC : clka cycles from a sel_clkb change until done (>= 1)
//   DWELL_CYC  : clka cycles after done before the next request (>= 0)
//   CNT_W      : settle/dwell counter width (both counts < 2**CNT_W)
//
// Ports
//   clka     in   controller clock (always running)
//   rst_n    in   asynchronous active-low reset (release synchronized upstream)
//   req_vld  in   switch request valid
//   req_sel  in   requested source, 0 = clka, 1 = clkb (sampled on handshake)
//   req_rdy  out  controller can accept a request (FSM in IDLE)
//   sel_clkb out  registered mux select
//   busy     out  FSM not in IDLE
//   done     out  one-cycle pulse when a request completes
//   sw_cnt   out  count of real source changes, wraps at 256
// ---------------------------------------------------------------------------
module clk_sw_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_CYC  = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clka,
  input  logic       rst_n,
  input  logic       req_vld,
  input  logic       req_sel,
  output logic       req_rdy,
  output logic       sel_clkb,
  output logic       busy,
  output logic       done,
  output logic [7:0] sw_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_e;

  // Reload values; the dwell reload is guarded so DWELL_CYC = 0 never
  // produces a negative constant.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'((DWELL_CYC > 0) ? DWELL_CYC - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             done_q, done_d;
  logic             noop_q, noop_d;
  logic [7:0]       sw_cnt_q, sw_cnt_d;

  logic             hs;
  logic             cnt_zero;

  assign hs       = req_vld && (state_q == IDLE);
  assign cnt_zero = (cnt_q == '0);

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      noop_q   <= 1'b0;
      sw_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      noop_q   <= noop_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    sw_cnt_d = sw_cnt_q;
    noop_d   = 1'b0;
    // A no-op request is acknowledged one cycle later than its handshake,
    // matching the latency of a real switch with a one-cycle settle.
    done_d   = noop_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (req_sel != sel_q) begin
            sel_d    = req_sel;
            sw_cnt_d = sw_cnt_q + 8'd1;
            cnt_d    = SETTLE_LD;
            state_d  = SETTLE;
          end else begin
            noop_d   = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          done_d = 1'b1;
          if (DWELL_CYC == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = DWELL_LD;
            state_d = DWELL;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DWELL: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: registers or decodes of the state register only, so there is
  // no combinational path from req_* to any output.
  always_comb begin
    req_rdy  = (state_q == IDLE);
    busy     = (state_q != IDLE);
    sel_clkb = sel_q;
    done     = done_q;
    sw_cnt   = sw_cnt_q;
  end

endmodule
